// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared constants and types for the FIFO write-side arbiter.
//
//   DATA_W  : width of one requester's data word / FIFO write word
//   NUM_REQ : number of requesters (fixed at 4)
//   IDX_W   : width of a requester index
//   arb_state_t : arbiter FSM encoding (IDLE = 0, GRANT = 1)
//   idx_to_onehot : converts a requester index to a one-hot grant vector
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  localparam int DATA_W  = 8;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Searches the request vector starting
//   one position above rr_ptr and wrapping around, so the requester at rr_ptr
//   itself is considered last.
//
//   Ports:
//     req    in  [NUM_REQ-1:0]  request vector, bit i = requester i
//     rr_ptr in  [IDX_W-1:0]    index of the most recently served requester
//     valid  out                at least one request bit is set
//     idx    out [IDX_W-1:0]    selected requester (rr_ptr when valid = 0)
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest; a later (nearer) hit overwrites an
  // earlier one, so the nearest set bit above rr_ptr wins. Offset NUM_REQ
  // wraps back to rr_ptr itself, giving it the lowest priority.
  always_comb begin
    valid = 1'b0;
    idx   = rr_ptr;
    cand  = rr_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = rr_ptr + IDX_W'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Arbitrates four requesters onto the write port of a FIFO. In IDLE a
//   round-robin pick registers a one-hot grant; in GRANT the granted
//   requester writes up to BURST_LEN words, stalling while the FIFO is full.
//   The burst ends after BURST_LEN writes or as soon as the granted requester
//   drops its request. The served requester becomes lowest priority next time.
//
//   Handshake: a word from requester g is transferred in a cycle exactly when
//   grant[g] = 1, req[g] = 1 and full = 0; that cycle shows wd_en = 1 and
//   ack[g] = 1. Anything else transfers nothing.
//
//   Parameters:
//     BURST_LEN  maximum words per grant (1..15)
//     NUM_REQ    number of requesters (fixed at 4)
//
//   Ports:
//     w_clk     in   write-domain clock
//     rst_n     in   asynchronous active-low reset
//     req       in   [3:0]  per-requester write request
//     req_data  in   [31:0] requester i data in bits [8i+7:8i]
//     full      in   FIFO full flag
//     wd_en     out  FIFO write enable
//     d_in      out  [7:0]  FIFO write data (0 while idle)
//     grant     out  [3:0]  registered one-hot grant, 0 while idle
//     ack       out  [3:0]  one-hot, requester's word written this cycle
//     busy      out  high while the FSM is in GRANT (FSM state view)
//
//   Build option:
//     HIPRI_REQ0_EN  when defined, requester 0 wins every IDLE arbitration it
//                    takes part in; such wins leave rr_ptr untouched.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int NUM_REQ   = 4
) (
  input  logic                      w_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      full,
  output logic                      wd_en,
  output logic [DATA_W-1:0]         d_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy
);

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  arb_state_t         state, state_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic [IDX_W-1:0]   gnt_idx, gnt_idx_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [3:0]         beat_cnt, beat_cnt_nxt;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // ---------------------------------------------------------------------------
  // Output decode. Everything is derived from the registered state, so an
  // asynchronous reset clears the outputs without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy  = (state == GRANT);
    wd_en = busy & req[gnt_idx] & ~full;
    ack   = wd_en ? grant_q : '0;
    grant = grant_q;
  end

  always_comb begin
    d_in = '0;
    if (busy) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_idx == IDX_W'(i)) begin
          d_in = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_q;
    gnt_idx_nxt  = gnt_idx;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;

    case (state)
      IDLE: begin
        grant_nxt = '0;
`ifdef HIPRI_REQ0_EN
        if (req[0]) begin
          // Priority win: rr_ptr keeps pointing at the last round-robin
          // winner so the rotation among the others is not disturbed.
          state_nxt    = GRANT;
          gnt_idx_nxt  = '0;
          grant_nxt    = idx_to_onehot('0);
          beat_cnt_nxt = '0;
        end else if (pick_valid) begin
          state_nxt    = GRANT;
          gnt_idx_nxt  = pick_idx;
          rr_ptr_nxt   = pick_idx;
          grant_nxt    = idx_to_onehot(pick_idx);
          beat_cnt_nxt = '0;
        end
`else
        if (pick_valid) begin
          state_nxt    = GRANT;
          gnt_idx_nxt  = pick_idx;
          rr_ptr_nxt   = pick_idx;
          grant_nxt    = idx_to_onehot(pick_idx);
          beat_cnt_nxt = '0;
        end
`endif
      end

      GRANT: begin
        if (!req[gnt_idx]) begin
          // Request withdrawn: end the burst. This also covers a request
          // drop coinciding with full, where no word is written.
          state_nxt = IDLE;
          grant_nxt = '0;
        end else if (wd_en) begin
          beat_cnt_nxt = beat_cnt + 4'd1;
          if (beat_cnt == LAST_BEAT) begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end
        // full with the request still held: hold everything, no timeout.
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. rr_ptr resets to the last index so requester 0 is the
  // first candidate after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      gnt_idx  <= '0;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      gnt_idx  <= gnt_idx_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 4, maximum words written per grant; legal range 1..15.
REQ-002 Parameter NUM_REQ, default 4, number of requesters; this block is fixed at 4.
REQ-003 w_clk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-requester write request; bit i corresponds to requester i.
REQ-006 req_data  input  32  per-requester data; requester i occupies bits [8i+7:8i].
REQ-007 full  input  1  FIFO full flag, write-domain synchronous.
REQ-008 wd_en  output  1  FIFO write-enable request.
REQ-009 d_in  output  8  FIFO write data.
REQ-010 grant  output  4  one-hot registered grant; all zero when idle.
REQ-011 ack  output  4  one-hot; bit i high means requester i's word is written this cycle.
REQ-012 busy  output  1  high while in state GRANT.

Function
REQ-013 The FSM SHALL have two states: IDLE and GRANT.
REQ-014 IDLE with req == 0: SHALL remain in IDLE, with grant = 0.
REQ-015 IDLE with req != 0: SHALL select the first set req bit searching from (rr_ptr+1) mod 4 upward with wrap, and register the one-hot grant.
  - Transition to GRANT; load rr_ptr with the selected index; clear beat_cnt.
  - Arbitration latency: one cycle from req to grant.
REQ-016 In GRANT with granted index g: wd_en = req[g] & ~full, combinational.
  - d_in = req_data slice g.
  - ack[g] = wd_en; all other ack bits 0.
REQ-017 Each cycle with wd_en = 1 SHALL increment beat_cnt (4-bit, no wrap within a burst).
REQ-018 GRANT SHALL return to IDLE and clear grant when either of the following holds:
  - wd_en = 1 and beat_cnt == BURST_LEN-1;
  - req[g] = 0.
REQ-019 full = 1 in GRANT SHALL hold the grant with wd_en = 0 and ack = 0; beat_cnt is unchanged and there is no timeout.
REQ-020 Simultaneous req[g] fall and full rise SHALL end the grant; no write occurs.
REQ-021 In IDLE: wd_en = 0, ack = 0, d_in = 0.
REQ-022 Requests from non-granted requesters SHALL be ignored until the next IDLE arbitration; at most one ack bit is ever set.
REQ-023 After any burst, the just-served requester SHALL have lowest priority at the next arbitration.

Reset
REQ-024 rst_n low SHALL immediately force the following, independent of w_clk, including mid-burst:
  - state = IDLE; grant = 0; beat_cnt = 0; rr_ptr = 3.
  - Hence wd_en = 0, ack = 0, d_in = 0, busy = 0.
REQ-025 The first arbitration after reset SHALL favour requester 0.

Configuration
REQ-026 With HIPRI_REQ0_EN defined, IDLE SHALL grant requester 0 whenever req[0] = 1, regardless of rr_ptr.
  - rr_ptr is not updated by such a priority grant.
REQ-027 Without HIPRI_REQ0_EN, arbitration SHALL be pure round-robin per REQ-015.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold:
  - DATA_W = 8, NUM_REQ = 4, IDX_W = 2;
  - the state encoding typedef (IDLE = 0, GRANT = 1).
REQ-029 Combinational sub-module rr_pick SHALL take (req, rr_ptr) and return (valid, idx).
REQ-030 The top level SHALL contain the FSM, beat counter, grant register and output muxing.

Verification
REQ-031 Reset with rr_ptr = 3; req = 4'b1111, full = 0, BURST_LEN = 4:
  - grants SHALL go 0,1,2,3,0;
  - each burst gives 4 acks;
  - 1 idle cycle between bursts.
REQ-032 req = 4'b0100 held; full = 1 for 3 cycles after the second beat:
  - grant[2] held throughout;
  - wd_en = 0 during full;
  - exactly 4 acks in total.
REQ-033 req[1] drops after 2 beats while req[3] = 1:
  - grant[1] SHALL end after 2 acks;
  - next grant SHALL be 4'b1000.
REQ-034 rst_n pulsed low mid-burst, asynchronously between edges:
  - grant, wd_en and ack SHALL go 0 immediately;
  - after release, req = 4'b1010 SHALL grant requester 1 first.
REQ-035 HIPRI_REQ0_EN defined, req = 4'b0011 continuous:
  - requester 0 SHALL be granted on every arbitration;
  - without the macro, grants SHALL alternate 0,1.
REQ-036 Data check: req_data = 32'hDDCCBBAA, req = 4'b0010:
  - d_in SHALL equal 8'hBB on each ack[1].
